// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared types for the hazard controller and its scoreboard.
// Revision : 1.0
// ============================================================================
package hazard_pkg;

  localparam int REG_IDX_W = 4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] dest;
  } sb_entry_t;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/pending_dest_pipe.sv
`default_nettype none
// ============================================================================
// Module   : pending_dest_pipe
// Purpose  : Shift register of in-flight write destinations with two compare ports.
// Revision : 1.0
// ============================================================================
module pending_dest_pipe
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_i,
  input  logic                 load_valid_i,
  input  logic [REG_IDX_W-1:0] load_dest_i,
  input  logic [REG_IDX_W-1:0] cmp_a_i,
  input  logic [REG_IDX_W-1:0] cmp_b_i,
  output logic                 hit_a_o,
  output logic                 hit_b_o
);

  sb_entry_t [DEPTH-1:0] pipe_q;
  sb_entry_t [DEPTH-1:0] pipe_d;
  logic      [DEPTH-1:0] w_hit_a;
  logic      [DEPTH-1:0] w_hit_b;

  always_comb begin
    pipe_d = pipe_q;
    if (shift_i) begin
      pipe_d[0].valid = load_valid_i;
      pipe_d[0].dest  = load_dest_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // The oldest entry is still compared: its write-back lands at the end of this cycle.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign w_hit_a[g] = pipe_q[g].valid && (pipe_q[g].dest == cmp_a_i);
    assign w_hit_b[g] = pipe_q[g].valid && (pipe_q[g].dest == cmp_b_i);
  end

  assign hit_a_o = |w_hit_a;
  assign hit_b_o = |w_hit_b;

endmodule : pending_dest_pipe
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Purpose  : RAW stall, jump flush and memory freeze control for an in-order pipeline.
// Revision : 1.0
// ============================================================================
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int PIPE_DEPTH   = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_src_a,
  input  logic [REG_IDX_W-1:0] id_src_b,
  input  logic                 id_uses_a,
  input  logic                 id_uses_b,
  input  logic [REG_IDX_W-1:0] id_dest,
  input  logic                 id_reg_write,
  input  logic                 ex_branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 bubble_ex,
  output logic                 flush_id,
  output logic                 freeze,
  output logic                 mem_timeout
);

  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam int TCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FCNT_W-1:0] FLUSH_FIRST = FCNT_W'(1);
  localparam logic [FCNT_W-1:0] FLUSH_LAST  = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX    = TCNT_W'(MEM_TIMEOUT);

  hz_state_e          state_q, state_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic               mem_timeout_q, mem_timeout_d;

  logic w_flush_active;
  logic w_hazard;
  logic w_issue;
  logic w_hit_a;
  logic w_hit_b;

  assign freeze         = mem_req && !mem_ready;
  assign w_flush_active = ((state_q == RUN) && ex_branch_taken) || (state_q == FLUSH);
  assign w_hazard       = id_valid && ((id_uses_a && w_hit_a) || (id_uses_b && w_hit_b));
  assign w_issue        = id_valid && id_reg_write && !w_flush_active && !w_hazard && !freeze;
  assign mem_timeout    = mem_timeout_q;

  pending_dest_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_pending_dest_pipe (
    .clk          (clk),
    .reset        (reset),
    .shift_i      (!freeze),
    .load_valid_i (w_issue),
    .load_dest_i  (id_dest),
    .cmp_a_i      (id_src_a),
    .cmp_b_i      (id_src_b),
    .hit_a_o      (w_hit_a),
    .hit_b_o      (w_hit_b)
  );

  // The triggering cycle counts as the first flush cycle, so FLUSH starts at 1.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (!freeze) begin
      if (ex_branch_taken) begin
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_FIRST;
        end else begin
          state_d = RUN;
          fcnt_d  = '0;
        end
      end else if (state_q == FLUSH) begin
        if (fcnt_q >= FLUSH_LAST) begin
          state_d = RUN;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    tcnt_d = '0;
    if (freeze) begin
      tcnt_d = (tcnt_q == TCNT_MAX) ? tcnt_q : tcnt_q + 1'b1;
    end
    mem_timeout_d = mem_timeout_q || (tcnt_d == TCNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      fcnt_q        <= '0;
      tcnt_q        <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      tcnt_q        <= tcnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Priority: freeze, then flush, then RAW hazard.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (!reset) begin
      if (freeze) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
      end else if (w_flush_active) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (w_hazard) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

endmodule : hazard_controller
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_controller
// Purpose  : Directed self-checking bench for hazard_controller.
// Revision : 1.0
// ============================================================================
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [3:0] id_src_a, id_src_b, id_dest;
  logic       id_uses_a, id_uses_b, id_reg_write;
  logic       ex_branch_taken, mem_req, mem_ready;
  logic       stall_if, stall_id, bubble_ex, flush_id, freeze, mem_timeout;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [5:0] exp_q[$];

  // Output vector order: {stall_if, stall_id, bubble_ex, flush_id, freeze, mem_timeout}
  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_STALL = 6'b111000;
  localparam logic [5:0] O_FLUSH = 6'b001100;
  localparam logic [5:0] O_FRZ   = 6'b110010;
  localparam logic [5:0] O_TO    = 6'b000001;

  always #5 clk = ~clk;

  hazard_controller #(
    .PIPE_DEPTH   (3),
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (64)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_src_a        (id_src_a),
    .id_src_b        (id_src_b),
    .id_uses_a       (id_uses_a),
    .id_uses_b       (id_uses_b),
    .id_dest         (id_dest),
    .id_reg_write    (id_reg_write),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .bubble_ex       (bubble_ex),
    .flush_id        (flush_id),
    .freeze          (freeze),
    .mem_timeout     (mem_timeout)
  );

  task automatic step(input string tag, input logic rst, input logic v, input logic rw,
                      input logic [3:0] dest, input logic ua, input logic [3:0] sa,
                      input logic ub, input logic [3:0] sb, input logic br,
                      input logic mq, input logic mr, input logic [5:0] exp);
    logic [5:0] obs;
    logic [5:0] want;
    @(negedge clk);
    reset = rst; id_valid = v; id_reg_write = rw; id_dest = dest;
    id_uses_a = ua; id_src_a = sa; id_uses_b = ub; id_src_b = sb;
    ex_branch_taken = br; mem_req = mq; mem_ready = mr;
    exp_q.push_back(exp);
    #1;
    obs  = {stall_if, stall_id, bubble_ex, flush_id, freeze, mem_timeout};
    want = exp_q.pop_front();
    n_checks++;
    assert (obs === want) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  task automatic idle(input string tag, input logic [5:0] exp);
    step(tag, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, exp);
  endtask

  task automatic wr(input string tag, input logic [3:0] d, input logic br, input logic [5:0] exp);
    step(tag, 1'b0, 1'b1, 1'b1, d, 1'b0, 4'd0, 1'b0, 4'd0, br, 1'b0, 1'b0, exp);
  endtask

  task automatic rd_a(input string tag, input logic [3:0] s, input logic mq, input logic mr,
                      input logic [5:0] exp);
    step(tag, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, s, 1'b0, 4'd0, 1'b0, mq, mr, exp);
  endtask

  task automatic br_cyc(input string tag, input logic br, input logic mq, input logic [5:0] exp);
    step(tag, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, br, mq, 1'b0, exp);
  endtask

  initial begin
    // Reset: control outputs forced low, freeze still combinational.
    step("rst_idle", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE);
    step("rst_frz",  1'b1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 6'b000010);
    idle("post_rst", O_NONE);

    // RAW on src_a: three stall cycles, then issue.
    wr("raw_wr_r3", 4'd3, 1'b0, O_NONE);
    rd_a("raw_a_s1", 4'd3, 1'b0, 1'b0, O_STALL);
    rd_a("raw_a_s2", 4'd3, 1'b0, 1'b0, O_STALL);
    rd_a("raw_a_s3", 4'd3, 1'b0, 1'b0, O_STALL);
    rd_a("raw_a_go", 4'd3, 1'b0, 1'b0, O_NONE);

    // RAW on src_b, and uses flags gating the compare.
    wr("raw_wr_r9", 4'd9, 1'b0, O_NONE);
    step("nouse_r9", 1'b0, 1, 0, 0, 1'b0, 4'd9, 1'b0, 4'd9, 0, 0, 0, O_NONE);
    step("raw_b_s1", 1'b0, 1, 0, 0, 1'b0, 4'd0, 1'b1, 4'd9, 0, 0, 0, O_STALL);
    step("raw_b_ret", 1'b0, 1, 0, 0, 1'b0, 4'd0, 1'b1, 4'd9, 0, 0, 0, O_STALL);
    step("raw_b_go", 1'b0, 1, 0, 0, 1'b0, 4'd0, 1'b1, 4'd9, 0, 0, 0, O_NONE);

    // Register 0 is tracked; invalid decode never stalls.
    wr("r0_wr", 4'd0, 1'b0, O_NONE);
    rd_a("r0_raw", 4'd0, 1'b0, 1'b0, O_STALL);
    step("r0_novalid1", 1'b0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 0, 0, O_NONE);
    step("r0_novalid2", 1'b0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 0, 0, O_NONE);
    rd_a("r0_retired", 4'd0, 1'b0, 1'b0, O_NONE);

    // Taken jump: two flush cycles, flushed writes never tracked.
    wr("br_trig", 4'd6, 1'b1, O_FLUSH);
    wr("br_fl2", 4'd6, 1'b0, O_FLUSH);
    rd_a("br_done", 4'd6, 1'b0, 1'b0, O_NONE);
    rd_a("br_nosb", 4'd6, 1'b0, 1'b0, O_NONE);

    // Taken jump inside FLUSH restarts the count.
    br_cyc("rs_trig", 1'b1, 1'b0, O_FLUSH);
    br_cyc("rs_again", 1'b1, 1'b0, O_FLUSH);
    br_cyc("rs_fl2", 1'b0, 1'b0, O_FLUSH);
    br_cyc("rs_done", 1'b0, 1'b0, O_NONE);

    // Freeze with r5 in entry 1: scoreboard holds, hazard resumes.
    wr("frz_wr_r5", 4'd5, 1'b0, O_NONE);
    rd_a("frz_e0", 4'd5, 1'b0, 1'b0, O_STALL);
    for (int i = 0; i < 5; i++) begin
      rd_a("frz_hold", 4'd5, 1'b1, 1'b0, O_FRZ);
    end
    rd_a("frz_e1", 4'd5, 1'b0, 1'b0, O_STALL);
    rd_a("frz_e2", 4'd5, 1'b0, 1'b0, O_STALL);
    rd_a("frz_ready", 4'd5, 1'b1, 1'b1, O_NONE);

    // Freeze beats a taken jump; flush starts once unfrozen.
    br_cyc("fb_frz", 1'b1, 1'b1, O_FRZ);
    br_cyc("fb_trig", 1'b1, 1'b0, O_FLUSH);
    br_cyc("fb_fl2", 1'b0, 1'b0, O_FLUSH);
    br_cyc("fb_done", 1'b0, 1'b0, O_NONE);

    // Freeze in FLUSH holds the flush counter.
    br_cyc("ff_trig", 1'b1, 1'b0, O_FLUSH);
    br_cyc("ff_frz", 1'b0, 1'b1, O_FRZ);
    br_cyc("ff_fl2", 1'b0, 1'b0, O_FLUSH);
    br_cyc("ff_done", 1'b0, 1'b0, O_NONE);

    // Reset in the second flush cycle with r7 pending.
    wr("rf_wr_r7", 4'd7, 1'b0, O_NONE);
    br_cyc("rf_trig", 1'b1, 1'b0, O_FLUSH);
    step("rf_rst", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE);
    rd_a("rf_after", 4'd7, 1'b0, 1'b0, O_NONE);

    // Freeze counter clears between stretches, then times out at 64.
    for (int i = 0; i < 40; i++) begin
      br_cyc("to_pre", 1'b0, 1'b1, O_FRZ);
    end
    idle("to_gap", O_NONE);
    for (int i = 1; i <= 64; i++) begin
      br_cyc("to_frz", 1'b0, 1'b1, O_FRZ);
    end
    step("to_ready", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_TO);
    idle("to_sticky", O_TO);
    step("to_rst", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_TO);
    idle("to_clear", O_NONE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_hazard_controller
`default_nettype wire
